// File: rtl/bitbakery_serial_rx.sv
// bitbakery_serial_rx
// UART receiver with a small command decoder on top.
// It samples an asynchronous serial line at DIVISOR clocks per bit. The default
// frame is 8N1. Each valid byte is latched into dado and then decoded on its top
// two bits (the tag).
//
// Optional feature: define BITBAKERY_RX_PARITY_EN to receive 8E1 frames. An even
// parity mismatch then pulses erro_paridade instead of pronto.
//
// Ports
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   entrada_serial  in   asynchronous serial line, idle high
//   dado            out  last valid received byte
//   pronto          out  one-cycle pulse per valid byte
//   minigame        out  tag 00: selected minigame (byte[5:4])
//   estado          out  tag 00: top-level state code (byte[3:0])
//   jogada          out  tag 01: move/buttons (byte[5:0])
//   dificuldade     out  tag 10: difficulty (byte[4])
//   player_position out  tag 10: delivery player position (byte[3:0])
//   erro_frame      out  one-cycle pulse when the stop bit is low
//   erro_paridade   out  one-cycle pulse on parity mismatch (0 without the macro)
module bitbakery_serial_rx #(
  parameter int DIVISOR = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       pronto,
  output logic [1:0] minigame,
  output logic [3:0] estado,
  output logic [5:0] jogada,
  output logic       dificuldade,
  output logic [3:0] player_position,
  output logic       erro_frame,
  output logic       erro_paridade
);

  localparam int CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int HALF = (DIVISOR / 2 > 0) ? DIVISOR / 2 : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef BITBAKERY_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t state, state_next;

  logic          sync1, sync2;
  logic [1:0]    warm;
  logic          line_prev;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          in_frame;
  logic          sample;
  logic          take_byte;
  logic          frame_err;
  logic          par_err;

  // Two-flop synchronizer. Both flops idle high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      sync2 <= sync1;
    end
  end

  // The synchronizer's reset value is not a real observation of the line.
  // line_prev is only allowed to see a genuine high once warm[1] is set.
  // Because of this, a line that is already low at reset release never looks
  // like a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      warm      <= '0;
      line_prev <= 1'b0;
    end else begin
      warm      <= {warm[0], 1'b1};
      line_prev <= sync2 & warm[1];
    end
  end

  assign fall = line_prev & ~sync2;

  always_comb begin
    in_frame = 1'b0;
    sample   = 1'b0;
    unique case (state)
      START: begin
        in_frame = 1'b1;
        sample   = (cnt == HALF_LAST);
      end
      DATA,
`ifdef BITBAKERY_RX_PARITY_EN
      PARITY,
`endif
      STOP: begin
        in_frame = 1'b1;
        sample   = (cnt == FULL_LAST);
      end
      default: ;
    endcase
  end

  // Baud counter. It restarts on every sample, so it never wraps mid-bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!in_frame || sample) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + 1'b1;
      shift   <= {sync2, shift[7:1]};
    end
  end

`ifdef BITBAKERY_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_bit <= 1'b0;
    end else if (state == PARITY && sample) begin
      par_bit <= sync2;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take_byte  = 1'b0;
    frame_err  = 1'b0;
    par_err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) state_next = START;
      end
      START: begin
        if (sample) state_next = sync2 ? IDLE : DATA;
      end
      DATA: begin
        if (sample && bit_cnt == 3'd7) begin
`ifdef BITBAKERY_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef BITBAKERY_RX_PARITY_EN
      PARITY: begin
        if (sample) state_next = STOP;
      end
`endif
      STOP: begin
        if (sample) begin
          state_next = IDLE;
          if (!sync2) begin
            frame_err = 1'b1;
          end else begin
`ifdef BITBAKERY_RX_PARITY_EN
            if ((^shift) ^ par_bit) par_err = 1'b1;
            else                    state_next = DONE;
`else
            state_next = DONE;
`endif
          end
        end
      end
      DONE: begin
        take_byte  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs are registered. pronto rises on the same edge that updates dado
  // and the decoded fields. Decoded fields that the tag does not address keep
  // their values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dado            <= '0;
      pronto          <= 1'b0;
      minigame        <= '0;
      estado          <= '0;
      jogada          <= '0;
      dificuldade     <= 1'b0;
      player_position <= '0;
      erro_frame      <= 1'b0;
    end else begin
      pronto     <= take_byte;
      erro_frame <= frame_err;
      if (take_byte) begin
        dado <= shift;
        unique case (shift[7:6])
          2'b00: begin
            minigame <= shift[5:4];
            estado   <= shift[3:0];
          end
          2'b01: jogada <= shift[5:0];
          2'b10: begin
            dificuldade     <= shift[4];
            player_position <= shift[3:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BITBAKERY_RX_PARITY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_paridade <= 1'b0;
    end else begin
      erro_paridade <= par_err;
    end
  end
`else
  logic unused_par;
  assign unused_par    = par_err;
  assign erro_paridade = 1'b0;
`endif

endmodule
